u_lsu: RTL
==========

U_LSU -- requirements
Module: u_lsu

Interface
REQ-001 SHALL have port i_sys_clock, input, 1, the single clock; all state updates on the rising edge.
REQ-002 SHALL have port i_sys_reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port i_u_lsu_req, input, 1, MEM-stage access request valid.
REQ-004 SHALL have port i_u_lsu_we, input, 1, 1=store, 0=load.
REQ-005 SHALL have port i_u_lsu_size, input, 2, 00=byte, 01=halfword, 10=word; 11 treated as word.
REQ-006 SHALL have port i_u_lsu_signed, input, 1, sign-extend loaded byte/halfword.
REQ-007 SHALL have port i_u_lsu_addr, input, 32, byte address.
REQ-008 SHALL have port i_u_lsu_wdata, input, 32, store data, right-justified.
REQ-009 SHALL have port o_u_lsu_stall, output, 1, hold the pipeline.
REQ-010 SHALL have port o_u_lsu_done, output, 1, access complete (one-cycle pulse).
REQ-011 SHALL have port o_u_lsu_rdata, output, 32, extended load result.
REQ-012 SHALL have port o_u_lsu_misaligned, output, 1, misaligned-access flag.
REQ-013 SHALL have ports o_u_lsu_mem_addr (32), o_u_lsu_mem_wdata (32), o_u_lsu_mem_wr (1), o_u_lsu_mem_word (1), outputs, data-memory request.
REQ-014 SHALL have port i_u_lsu_mem_data, input, 32, data-memory combinational read (word, or byte zero-extended in [7:0]).

Function
REQ-015 SHALL implement FSM IDLE, HI, RESP; the requester holds all i_u_lsu_* inputs stable while o_u_lsu_stall=1.
REQ-016 IDLE, req=1, size byte/word: SHALL issue the access this cycle, capture the read into an internal register at the edge, go to RESP.
REQ-017 IDLE, req=1, size half: SHALL issue a byte access at addr, go to HI; HI SHALL issue a byte access at addr+1 (32-bit wrap), then go to RESP.
REQ-018 SHALL assert o_u_lsu_stall=1 in IDLE with req=1 and in HI; 0 in RESP and in IDLE with req=0.
REQ-019 RESP SHALL assert o_u_lsu_done=1 and return to IDLE unconditionally, with no memory access and req ignored; back-to-back accesses therefore take 2 cycles (byte/word) or 3 cycles (half).
REQ-020 SHALL drive o_u_lsu_mem_word=1 for word accesses and 0 otherwise.
REQ-021 SHALL assert o_u_lsu_mem_wr only in the issuing cycle(s) of a store; it SHALL be 0 in RESP, in IDLE without req, and while i_sys_reset=1.
REQ-022 Store SHALL drive mem_wdata: wdata for word; {24'b0,wdata[7:0]} for byte and half low; {24'b0,wdata[15:8]} for half high.
REQ-023 Half load SHALL be little-endian: the low byte comes from addr and the high byte from addr+1.
REQ-024 o_u_lsu_rdata SHALL be held valid from RESP until the next RESP; for a byte load it SHALL be bit-7 sign- or zero-extended, for a half load bit-15 extended, and for a word load passed unchanged; stores SHALL leave it 0.
REQ-025 Idle memory outputs SHALL be 0: addr, wdata, wr and word.

Reset
REQ-026 Reset SHALL force IDLE, o_u_lsu_rdata=0, done=0, misaligned=0, internal low-byte register=0, stall=0.
REQ-027 Reset during HI SHALL abort the access: the second byte of a half store is not written and done is not pulsed.

Configuration
REQ-028 With U_LSU_MISALIGN_TRAP_EN defined, word accesses with addr[1:0]!=0 and half accesses with addr[0]=1 SHALL issue no memory access and go directly to RESP with misaligned=1, done=1 and rdata=0.
REQ-029 Without U_LSU_MISALIGN_TRAP_EN, misaligned is tied 0, word addresses SHALL have bits [1:0] cleared, and odd halfwords SHALL proceed normally via two byte accesses.

Verification
REQ-030 Word store 0xDEADBEEF to 0x10010004, then word load from the same address: rdata=0xDEADBEEF, done pulses, stall high for 1 cycle each.
REQ-031 Byte store 0x80 to 0x10010002, then signed byte load: rdata=0xFFFFFF80; the unsigned load gives 0x00000080 and the other bytes are unchanged.
REQ-032 Half store 0x1234 to 0x10010008: memory word reads 0x00001234; a signed half load of 0x8001 stored there gives 0xFFFF8001 with 3-cycle latency.
REQ-033 Word load from 0x10010006: with the macro, misaligned=1, rdata=0, no memory access; without it, the word at 0x10010004 is returned.
REQ-034 Assert reset in the HI cycle of a half store of 0xABCD to 0x10010010: the word reads 0x000000CD, the FSM is in IDLE, and done is never asserted.

Source files
------------

// File: rtl/u_lsu.sv
// Load/store unit: byte/word in one memory access, halfwords as two byte accesses.
// Optional misalignment trap is enabled with `define U_LSU_MISALIGN_TRAP_EN.
module u_lsu (
  input  logic        i_sys_clock,
  input  logic        i_sys_reset,
  input  logic        i_u_lsu_req,
  input  logic        i_u_lsu_we,
  input  logic [1:0]  i_u_lsu_size,
  input  logic        i_u_lsu_signed,
  input  logic [31:0] i_u_lsu_addr,
  input  logic [31:0] i_u_lsu_wdata,
  output logic        o_u_lsu_stall,
  output logic        o_u_lsu_done,
  output logic [31:0] o_u_lsu_rdata,
  output logic        o_u_lsu_misaligned,
  output logic [31:0] o_u_lsu_mem_addr,
  output logic [31:0] o_u_lsu_mem_wdata,
  output logic        o_u_lsu_mem_wr,
  output logic        o_u_lsu_mem_word,
  input  logic [31:0] i_u_lsu_mem_data
);

  typedef enum logic [1:0] {S_IDLE, S_HI, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  lo_q;
  logic [31:0] rdata_q;
  logic        stall_c, wr_c;

  logic is_word, is_half, trap;
  assign is_word = i_u_lsu_size[1];
  assign is_half = (i_u_lsu_size == 2'b01);

`ifdef U_LSU_MISALIGN_TRAP_EN
  logic mis_q;
  assign trap = (is_word && (i_u_lsu_addr[1:0] != 2'b00)) || (is_half && i_u_lsu_addr[0]);
  assign o_u_lsu_misaligned = mis_q;
`else
  assign trap = 1'b0;
  assign o_u_lsu_misaligned = 1'b0;
`endif

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic s);
    return s ? {{24{b[7]}}, b} : {24'b0, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic s);
    return s ? {{16{h[15]}}, h} : {16'b0, h};
  endfunction

  always_comb begin
    state_d           = state_q;
    stall_c           = 1'b0;
    wr_c              = 1'b0;
    o_u_lsu_done      = 1'b0;
    o_u_lsu_mem_addr  = '0;
    o_u_lsu_mem_wdata = '0;
    o_u_lsu_mem_word  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_u_lsu_req) begin
          stall_c = 1'b1;
          if (trap) begin
            state_d = S_RESP;
          end else if (is_word) begin
            wr_c              = i_u_lsu_we;
            o_u_lsu_mem_addr  = {i_u_lsu_addr[31:2], 2'b00};
            o_u_lsu_mem_wdata = i_u_lsu_wdata;
            o_u_lsu_mem_word  = 1'b1;
            state_d           = S_RESP;
          end else begin
            wr_c              = i_u_lsu_we;
            o_u_lsu_mem_addr  = i_u_lsu_addr;
            o_u_lsu_mem_wdata = {24'b0, i_u_lsu_wdata[7:0]};
            state_d           = is_half ? S_HI : S_RESP;
          end
        end
      end
      S_HI: begin
        stall_c           = 1'b1;
        wr_c              = i_u_lsu_we;
        o_u_lsu_mem_addr  = i_u_lsu_addr + 32'd1;
        o_u_lsu_mem_wdata = {24'b0, i_u_lsu_wdata[15:8]};
        state_d           = S_RESP;
      end
      S_RESP: begin
        o_u_lsu_done = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset must block writes and stalls even while the requester still holds req.
  assign o_u_lsu_mem_wr = wr_c & ~i_sys_reset;
  assign o_u_lsu_stall  = stall_c & ~i_sys_reset;
  assign o_u_lsu_rdata  = rdata_q;

  always_ff @(posedge i_sys_clock or posedge i_sys_reset) begin
    if (i_sys_reset) begin
      state_q <= S_IDLE;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (i_u_lsu_req) begin
            if (trap)
              rdata_q <= '0;
            else if (is_half)
              lo_q <= i_u_lsu_mem_data[7:0];
            else if (i_u_lsu_we)
              rdata_q <= '0;
            else
              rdata_q <= is_word ? i_u_lsu_mem_data
                                 : ext8(i_u_lsu_mem_data[7:0], i_u_lsu_signed);
          end
        end
        S_HI: rdata_q <= i_u_lsu_we ? '0
                         : ext16({i_u_lsu_mem_data[7:0], lo_q}, i_u_lsu_signed);
        default: ;
      endcase
    end
  end

`ifdef U_LSU_MISALIGN_TRAP_EN
  // Flag lives for exactly the RESP cycle that follows a trapped request.
  always_ff @(posedge i_sys_clock or posedge i_sys_reset) begin
    if (i_sys_reset) mis_q <= 1'b0;
    else             mis_q <= (state_q == S_IDLE) && i_u_lsu_req && trap;
  end
`endif

endmodule
